// File: rtl/pipelined_cs_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-wide carry-select slice per stage,
// block carry registered between stages, valid/ready on both sides with a global stall.
module pipelined_cs_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / BLOCK;
    localparam int LAST   = STAGES - 1;

    if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_param_check
        $error("pipelined_cs_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Per-stage state. Operands are shifted right as blocks complete, so the block a
    // stage works on always sits in bits [BLOCK-1:0]; st_sum holds the completed low bits.
    logic             st_valid [STAGES];
    logic             st_carry [STAGES];
    logic [WIDTH-1:0] st_a     [STAGES];
    logic [WIDTH-1:0] st_b     [STAGES];
    logic [WIDTH-1:0] st_sum   [STAGES];

    logic [BLOCK:0]   blk_res  [STAGES];

    logic             advance;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_cout;
    logic             fin_c_msb;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // NOTE: every array element is assigned on every pass through this block, so no
    // path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        logic [BLOCK:0] ripple0;
        logic [BLOCK:0] ripple1;
        for (int k = 0; k < STAGES; k++) begin
            ripple0    = {1'b0, st_a[k][BLOCK-1:0]} + {1'b0, st_b[k][BLOCK-1:0]};
            ripple1    = {1'b0, st_a[k][BLOCK-1:0]} + {1'b0, st_b[k][BLOCK-1:0]}
                         + (BLOCK + 1)'(1);
            blk_res[k] = st_carry[k] ? ripple1 : ripple0;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so each
    // stage samples the previous stage's pre-edge value and the pipeline shifts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st_valid[k] <= 1'b0;
            end
        end else if (advance) begin
            st_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                st_valid[k] <= st_valid[k-1];
            end
        end
    end

    // NOTE: pipeline data registers carry no reset; the valid bits qualify them, and
    // a stale payload behind valid=0 is never observed.
    always_ff @(posedge clk) begin
        if (advance) begin
            st_a[0]     <= a;
            st_b[0]     <= sub ? ~b : b;
            st_carry[0] <= sub | c_in;
            st_sum[0]   <= '0;
            for (int k = 1; k < STAGES; k++) begin
                st_a[k]     <= st_a[k-1] >> BLOCK;
                st_b[k]     <= st_b[k-1] >> BLOCK;
                st_carry[k] <= blk_res[k-1][BLOCK];
                st_sum[k]   <= st_sum[k-1]
                               | (WIDTH'(blk_res[k-1][BLOCK-1:0]) << ((k - 1) * BLOCK));
            end
        end
    end

    // Carry into the MSB is recovered from the MSB's own sum bit and operand bits.
    assign fin_sum   = st_sum[LAST] | (WIDTH'(blk_res[LAST][BLOCK-1:0]) << (LAST * BLOCK));
    assign fin_cout  = blk_res[LAST][BLOCK];
    assign fin_c_msb = st_a[LAST][BLOCK-1] ^ st_b[LAST][BLOCK-1] ^ blk_res[LAST][BLOCK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= st_valid[LAST];
            if (st_valid[LAST]) begin
                sum   <= fin_sum;
                c_out <= fin_cout;
                ovf   <= fin_cout ^ fin_c_msb;
                zero  <= (fin_sum == '0);
            end
        end
    end

endmodule

// File: doc/pipelined_cs_adder.md
# pipelined_cs_adder

Parametrised, pipelined carry-select adder/subtractor that generalises the ALU's 8-bit combinational adder to any width that is a multiple of the block size. One carry-select block is evaluated per pipeline stage, and the block carry is registered between stages. A valid/ready handshake sits on both sides, so the block can be fed at full rate by the ALU datapath and stalled by its consumer. It adds subtract mode and status flags (carry, signed overflow, zero), which the 8-bit adder does not have.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of BLOCK, ≥ BLOCK.
- BLOCK, 4: carry-select block width; one block per pipeline stage.
- (derived) STAGES = WIDTH/BLOCK: pipeline depth and latency in cycles.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in; used only when sub=0.
- sub  in  1  1: A − B (A + ~B + 1, c_in ignored); 0: A + B + c_in.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  carry out of the MSB; in subtract mode, 1 means no borrow (A ≥ B unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

## Operation
- Beat accepted when in_valid && in_ready. a, b (inverted if sub), carry-in and a valid bit enter stage 0.
- Stage k computes bits [k·BLOCK +: BLOCK].
  - Two precomputed ripple sums are formed, one for carry 0 and one for carry 1.
  - The registered carry from stage k−1 selects between them (stage 0 uses the effective carry-in).
- Per stage, registered: completed low sum bits, remaining unprocessed operand bits, block carry, valid.
- Last stage registers sum, c_out, ovf and zero into the output register. ovf uses the carry into bit WIDTH−1, captured within the last block.
- Global stall: advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance=0, every stage and the output register hold their contents.
- Bubbles (valid=0) propagate normally. A bubble reaching the output clears out_valid when advance=1.
- No reordering: results leave in acceptance order, one per accepted beat.
- Data registers with valid=0 may hold stale values. sum/flags are only meaningful while out_valid=1.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits 0, out_valid 0, sum 0, c_out 0, ovf 0, zero 0. in_ready = 1 immediately, because out_valid is 0.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES, given no stall.
- Throughput: one beat per cycle while out_ready=1.
- Output held stable (sum, flags, out_valid) while out_valid && !out_ready.
- Accept and drain in the same cycle (out_valid && out_ready && in_valid) is legal. The pipeline shifts, and both transfers occur.
- Full pipeline: up to STAGES+… beats in flight, one per stage plus the output register. No beat is dropped or duplicated under any stall pattern.
- Reset mid-operation: all in-flight beats are discarded. The first post-reset result is from the first post-reset accepted beat.
- Wrap-around: sum is modulo 2^WIDTH. The carry is reported only via c_out.

## Test plan
- Reset, then add with WIDTH=16, BLOCK=4: a=0x1234, b=0x4321, c_in=1, sub=0, out_ready=1.
  - Required: sum=0x5556, c_out=0, ovf=0, zero=0.
  - out_valid rises exactly 4 cycles after acceptance.
- Carry through every block: a=0xFFFF, b=0x0000, c_in=1.
  - Required: sum=0x0000, c_out=1, zero=1, ovf=0.
- Subtract with signed overflow: a=0x8000, b=0x0001, sub=1, c_in=1 (ignored).
  - Required: sum=0x7FFF, c_out=1, ovf=1.
- Subtract with borrow: a=0x0003, b=0x0005, sub=1.
  - Required: sum=0xFFFE, c_out=0, ovf=0.
- Back-to-back stream with backpressure: 20 random beats, in_valid=1 every cycle; out_ready toggled pseudo-randomly.
  - Required: every result matches the reference model in order, with no loss or duplication.
  - in_ready=0 exactly when out_valid && !out_ready; outputs stable during stalls.
- Async reset mid-stream: with 3 beats in flight, assert rst_n low between clock edges.
  - Required: out_valid=0 and sum=0 immediately.
  - After release, one new beat (a=0x0001, b=0x0001) yields sum=0x0002 only, with no stale results.
